// File: rtl/masked_and_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : masked_and_sequencer
// Brief   : Share-splitting initiator for a D-share masked AND gadget, with
//           LFSR randomness, gadget resynchronisation and a valid/ready result.
// Revision: 1.0 - initial release
// ============================================================================
module masked_and_sequencer #(
  parameter int          D         = 3,
  parameter int          LAT       = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   a_in,
  input  logic                   b_in,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_y,
  input  logic                   reseed,
  input  logic [15:0]            reseed_val,
  output logic [0:D-1]           and_ina,
  output logic [0:D-1]           and_inb,
  output logic [0:D*(D-1)/2-1]   and_rin,
  output logic                   and_enable,
  input  logic                   and_done,
  input  logic [0:D-1]           and_out,
  output logic                   err
);

  localparam int RS = D * (D - 1) / 2;
  localparam int R  = 2 * (D - 1) + RS;
  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_CAPT    = 3'd2,
    S_SYNC_HI = 3'd3,
    S_SYNC_LO = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [15:0]     r_lfsr;
  logic [15:0]     w_lfsr_adv;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_pulse;
  logic [0:D-1]    r_ina;
  logic [0:D-1]    r_inb;
  logic [0:RS-1]   r_rin;
  logic [0:D-1]    w_a_sh;
  logic [0:D-1]    w_b_sh;
  logic [0:RS-1]   w_rin;
  logic            r_y;
  logic            r_err;
  logic            w_accept;
  logic            w_xa;
  logic            w_xb;

  assign w_accept = (r_state == S_IDLE) && req_valid;

  always_comb begin
    w_lfsr_adv = r_lfsr;
    for (int s = 0; s < R; s++) begin
      w_lfsr_adv = {w_lfsr_adv[14:0],
                    w_lfsr_adv[15] ^ w_lfsr_adv[13] ^ w_lfsr_adv[12] ^ w_lfsr_adv[10]};
    end
  end

  // Share 0 absorbs the operand so that the XOR of all shares is the operand.
  always_comb begin
    w_a_sh = '0;
    w_b_sh = '0;
    w_rin  = '0;
    w_xa   = a_in;
    w_xb   = b_in;
    for (int i = 1; i < D; i++) begin
      w_a_sh[i] = r_lfsr[i-1];
      w_b_sh[i] = r_lfsr[D-2+i];
      w_xa      = w_xa ^ r_lfsr[i-1];
      w_xb      = w_xb ^ r_lfsr[D-2+i];
    end
    w_a_sh[0] = w_xa;
    w_b_sh[0] = w_xb;
    for (int k = 0; k < RS; k++) begin
      w_rin[k] = r_lfsr[2*(D-1)+k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (req_valid) w_next = S_RUN;
      S_RUN:     if (r_cnt == CW'(LAT - 1)) w_next = S_CAPT;
      S_CAPT:    w_next = and_done ? S_RESP : S_SYNC_HI;
      S_SYNC_HI: w_next = S_SYNC_LO;
      S_SYNC_LO: w_next = (and_done || (r_pulse == CW'(LAT))) ? S_RUN : S_SYNC_HI;
      S_RESP:    if (resp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr  <= LFSR_SEED;
      r_cnt   <= '0;
      r_pulse <= '0;
      r_ina   <= '0;
      r_inb   <= '0;
      r_rin   <= '0;
      r_y     <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (reseed) begin
        r_lfsr <= (reseed_val == 16'h0000) ? LFSR_SEED : reseed_val;
      end else if (w_accept) begin
        r_lfsr <= w_lfsr_adv;
      end

      r_cnt <= (r_state == S_RUN) ? r_cnt + 1'b1 : '0;

      if (r_state == S_SYNC_HI) begin
        r_pulse <= r_pulse + 1'b1;
      end else if (r_state == S_CAPT) begin
        r_pulse <= '0;
      end

      if (w_accept) begin
        r_ina <= w_a_sh;
        r_inb <= w_b_sh;
        r_rin <= w_rin;
      end else if ((r_state == S_RESP) && resp_ready) begin
        r_ina <= '0;
        r_inb <= '0;
        r_rin <= '0;
        r_y   <= 1'b0;
      end

      if (r_state == S_CAPT) begin
        if (and_done) begin
          r_y <= ^and_out;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_y     = r_y;
  assign and_enable = (r_state == S_RUN) || (r_state == S_SYNC_HI);
  assign and_ina    = r_ina;
  assign and_inb    = r_inb;
  assign and_rin    = r_rin;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_masked_and_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_masked_and_sequencer
// Brief   : Directed self-checking bench with a behavioural 3-share AND gadget.
// Revision: 1.0 - initial release
// ============================================================================
module tb_masked_and_sequencer;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        a_in = 1'b0;
  logic        b_in = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_y;
  logic        reseed = 1'b0;
  logic [15:0] reseed_val = 16'h0000;
  logic [0:2]  and_ina;
  logic [0:2]  and_inb;
  logic [0:2]  and_rin;
  logic        and_enable;
  logic        and_done;
  logic [0:2]  and_out;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  masked_and_sequencer #(.D(3), .LAT(LAT), .LFSR_SEED(16'hACE1)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_y     (resp_y),
    .reseed     (reseed),
    .reseed_val (reseed_val),
    .and_ina    (and_ina),
    .and_inb    (and_inb),
    .and_rin    (and_rin),
    .and_enable (and_enable),
    .and_done   (and_done),
    .and_out    (and_out),
    .err        (err)
  );

  // Gadget model: free-running counter without reset, done after LAT enabled edges.
  logic       stray = 1'b0;
  logic [1:0] g_cnt = 2'd0;
  logic       g_done = 1'b0;
  logic [0:2] g_out = 3'b000;
  logic       g_y;
  assign g_y      = (^and_ina) & (^and_inb);
  assign and_done = g_done;
  assign and_out  = g_out;

  always @(posedge clk) begin
    if (and_enable || stray) begin
      g_cnt  <= (g_cnt == 2'(LAT - 1)) ? 2'd0 : g_cnt + 2'd1;
      g_done <= (g_cnt == 2'(LAT - 1));
      if (g_cnt == 2'(LAT - 1)) begin
        g_out <= {g_y ^ and_rin[0] ^ and_rin[1], and_rin[0], and_rin[1]};
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge following the accept edge T0.
  task automatic start_op(input logic a, input logic b);
    int k;
    k = 0;
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("idle_timeout", 32'd1, 32'd0);
    a_in = a;
    b_in = b;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output int en_cnt);
    lat = 0;
    en_cnt = 0;
    while (!resp_valid && lat < 100) begin
      if (and_enable) en_cnt++;
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) check("resp_timeout", 32'd1, 32'd0);
  endtask

  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_ready_back"}, req_ready, 1'b1);
    check({tag, "_ina_clr"}, and_ina, 3'b000);
  endtask

  initial begin
    int lat, en;
    logic a, b;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_y", resp_y, 1'b0);
    check("rst_enable", and_enable, 1'b0);
    check("rst_ina", and_ina, 3'b000);
    check("rst_rin", and_rin, 3'b000);
    check("rst_err", err, 1'b0);

    // First operation with the default seed: r = 7'h61.
    start_op(1'b1, 1'b1);
    check("t1_req_ready", req_ready, 1'b0);
    check("t1_ina", and_ina, 3'b010);
    check("t1_inb", and_inb, 3'b100);
    check("t1_rin", and_rin, 3'b011);
    wait_resp(lat, en);
    check("t1_en_cycles", en, 3);
    check("t1_latency", lat, 4);
    check("t1_resp_y", resp_y, 1'b1);
    check("t1_err", err, 1'b0);
    finish_resp("t1");

    // All four operand combinations.
    for (int i = 0; i < 4; i++) begin
      a = i[1];
      b = i[0];
      start_op(a, b);
      check("combo_xor_a", ^and_ina, a);
      check("combo_xor_b", ^and_inb, b);
      wait_resp(lat, en);
      check("combo_latency", lat, 4);
      check("combo_resp_y", resp_y, a & b);
      finish_resp("combo");
    end

    // Backpressure: response held, new requests ignored.
    start_op(1'b1, 1'b1);
    wait_resp(lat, en);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      a_in = 1'b0;
      @(negedge clk);
      check("hold_valid", resp_valid, 1'b1);
      check("hold_y", resp_y, 1'b1);
      check("hold_req_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    finish_resp("hold");

    // Misaligned gadget: one stray enable edge before the request.
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    start_op(1'b1, 1'b0);
    wait_resp(lat, en);
    check("sync_err", err, 1'b1);
    check("sync_latency", lat, 12);
    check("sync_resp_y", resp_y, 1'b0);
    finish_resp("sync");
    start_op(1'b1, 1'b1);
    wait_resp(lat, en);
    check("post_sync_latency", lat, 4);
    check("post_sync_y", resp_y, 1'b1);
    finish_resp("post_sync");

    // Asynchronous reset two edges into RUN.
    start_op(1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req_ready", req_ready, 1'b1);
    check("arst_resp_valid", resp_valid, 1'b0);
    check("arst_enable", and_enable, 1'b0);
    check("arst_ina", and_ina, 3'b000);
    check("arst_inb", and_inb, 3'b000);
    check("arst_rin", and_rin, 3'b000);
    check("arst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(1'b1, 1'b1);
    check("arst_reseeded_ina", and_ina, 3'b010);
    wait_resp(lat, en);
    check("arst_latency", lat, 10);
    check("arst_resp_y", resp_y, 1'b1);
    check("arst_err_set", err, 1'b1);
    finish_resp("arst");

    // Reseed with zero and with the seed value both reproduce the first shares.
    for (int i = 0; i < 2; i++) begin
      reseed = 1'b1;
      reseed_val = (i == 0) ? 16'h0000 : 16'hACE1;
      @(negedge clk);
      reseed = 1'b0;
      start_op(1'b1, 1'b1);
      check("reseed_ina", and_ina, 3'b010);
      check("reseed_inb", and_inb, 3'b100);
      check("reseed_rin", and_rin, 3'b011);
      if (i == 1) begin
        reseed = 1'b1;
        reseed_val = 16'h1234;
        @(negedge clk);
        reseed = 1'b0;
        check("midrun_ina", and_ina, 3'b010);
        check("midrun_inb", and_inb, 3'b100);
      end
      wait_resp(lat, en);
      check("reseed_y", resp_y, 1'b1);
      finish_resp("reseed");
    end

    // The mid-run reseed takes effect on the following operation: r = 7'h34.
    start_op(1'b1, 1'b1);
    check("seed1234_ina", and_ina, 3'b100);
    check("seed1234_inb", and_inb, 3'b010);
    check("seed1234_rin", and_rin, 3'b110);
    wait_resp(lat, en);
    check("seed1234_y", resp_y, 1'b1);
    finish_resp("seed1234");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/masked_and_sequencer.md
# masked_and_sequencer

Initiator for the D-share masked AND gadget. It accepts one pair of unmasked operand bits and splits each into D Boolean shares using an internal LFSR. It supplies the gadget's D(D-1)/2 refresh bits, drives the gadget enable for exactly the gadget latency, and collects the output shares. It then recombines them and returns the unmasked product on a valid/ready response port. A resynchronisation path realigns the gadget's free-running internal counter, which has no reset, after a missed done.

## Interface
- D, 3, share count (D ≥ 2)
- LAT, 3, gadget latency: enabled clock edges from enable-high to and_done/and_out valid
- LFSR_SEED, 16'hACE1, LFSR reset and reseed value (nonzero)
- Derived: RS = D(D-1)/2; R = 2(D-1)+RS random bits per operation (R ≤ 16)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  operand request
- req_ready  out  1  sequencer idle, can accept
- a_in, b_in  in  1 each  unmasked operands
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_y  out  1  a_in AND b_in
- reseed  in  1  load reseed_val into LFSR (zero value loads LFSR_SEED)
- reseed_val  in  16  reseed value
- and_ina, and_inb  out  [0:D-1]  operand shares to gadget
- and_rin  out  [0:RS-1]  gadget refresh randomness
- and_enable  out  1  gadget enable
- and_done  in  1  gadget done flag
- and_out  in  [0:D-1]  gadget output shares
- err  out  1  sticky misalignment flag

## Operation
- LFSR: 16-bit Fibonacci; each step shifts left with bit0 = s[15]^s[13]^s[12]^s[10].
  - Advances R steps (unrolled) on each accepted request only.
  - reseed has priority over advance.
- Random bits r = LFSR[R-1:0], sampled at accept.
- Share assignment:
  - a_sh[i] = r[i-1] and b_sh[i] = r[D-2+i] for i = 1..D-1.
  - a_sh[0] = a_in ^ XOR(a_sh[1..D-1]); b_sh[0] likewise.
  - rin[k] = r[2(D-1)+k].
- Shares and rin are registered onto the gadget ports at accept. They are held constant until the response is accepted, then cleared to 0.
- States:
  - IDLE: req_ready=1. req_valid → RUN.
  - RUN: and_enable=1 for exactly LAT cycles → CAPT.
  - CAPT: and_enable=0. At this edge, sample and_out and and_done.
    - and_done=1 → resp_y = XOR(and_out), go to RESP.
    - and_done=0 → set err, go to SYNC.
  - SYNC: alternate one enable-high cycle and one enable-low observe cycle.
    - If and_done=1 is observed in the low cycle → RUN, rerunning with the same shares.
    - Give up after LAT pulses and go to RUN anyway; err remains set.
  - RESP: resp_valid=1 and resp_y held until resp_ready → IDLE.
- Reset mid-operation forces IDLE immediately with all outputs at reset values. Gadget misalignment is then corrected by SYNC on the next operation.
- reseed arriving during an operation does not alter the shares already registered.

## Timing
- Reset values:
  - req_ready=1; resp_valid=0; resp_y=0.
  - and_enable=0; and_ina/and_inb/and_rin all 0.
  - err=0; LFSR=LFSR_SEED; state IDLE.
- Accept edge T0 (req_valid & req_ready):
  - req_ready falls.
  - Shares are valid on the gadget ports and and_enable=1 from T0.
- Enabled edges T1..TLAT. and_enable falls at edge TLAT.
- Capture at edge TLAT+1. resp_valid rises there, giving latency LAT+1 = 4 cycles for D=3.
- Response handshake:
  - resp_ready high in the same cycle resp_valid rises → IDLE at the next edge.
  - req_ready returns 1 one cycle after the response handshake; there is no back-to-back accept.
- SYNC adds 2 cycles per pulse, plus a full rerun of LAT+1 cycles.
- req_valid while busy is ignored; it is not queued.

## Test plan
- Reset, then a=1, b=1 with default seed (r=7'h61):
  - ina={0,1,0}, inb={1,0,0}, rin={0,1,1}.
  - and_enable high exactly 3 cycles.
  - resp_valid at T0+4 with resp_y=1; err=0.
- All four a/b combinations back-to-back with a behavioural gadget model: resp_y equals a&b, and the share XORs equal a and b.
- Hold resp_ready=0 for 5 cycles: resp_valid/resp_y stable, req_ready=0, req_valid ignored. Release: IDLE next edge.
- Pre-advance the gadget counter by 1 (stray enable pulse), then request a=1, b=0:
  - err=1 at capture; SYNC pulses until and_done is seen.
  - Rerun gives resp_y=0; the next operation completes without additional SYNC.
- Assert rst_n low at T0+2:
  - All outputs are at reset values asynchronously.
  - After release, the next operation still returns the correct product.
- reseed with 0 vs 16'hACE1: identical share vectors on the next operation. reseed asserted mid-RUN: current ina unchanged.
